// File: rtl/sd_pkg.sv
// Shared types and constants for the SD CMD-line engine: FSM states, register
// addresses, response-type codes and CMD frame geometry.
package sd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_RESP,
        S_RECV,
        S_GAP
    } sd_state_e;

    localparam logic [2:0] ADDR_ARG      = 3'd0;
    localparam logic [2:0] ADDR_CTRL     = 3'd1;
    localparam logic [2:0] ADDR_STATUS   = 3'd2;
    localparam logic [2:0] ADDR_RESP_ARG = 3'd3;
    localparam logic [2:0] ADDR_RESP_HDR = 3'd4;
    localparam logic [2:0] ADDR_CLKDIV   = 3'd5;

    localparam logic [1:0] RESP_NONE  = 2'd0;
    localparam logic [1:0] RESP_CRC   = 2'd1;
    localparam logic [1:0] RESP_NOCRC = 2'd2;

    localparam logic [6:0] CRC7_POLY = 7'h09;
    localparam int         FRAME_LEN = 48;
    localparam int         CRC_BITS  = 40;

    function automatic logic expects_resp(input logic [1:0] resp_type);
        return (resp_type == RESP_CRC) || (resp_type == RESP_NOCRC);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Bit-serial CRC7 (x^7 + x^3 + 1) with synchronous clear; clear wins over enable.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_bit,
    output logic [6:0] crc
);

    logic feedback;
    assign feedback = data_bit ^ crc[6];

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            crc <= '0;
        else if (clear)
            crc <= '0;
        else if (enable)
            crc <= {crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
    end

endmodule

// File: rtl/sd_cmd_engine.sv
// Avalon-MM SD native-mode CMD-line engine: sd_clk divider, 48-bit command
// serialiser with CRC7, and response capture with timeout and CRC checking.
module sd_cmd_engine
    import sd_pkg::*;
#(
    parameter int DIV_W        = 8,
    parameter int RESP_TIMEOUT = 64,
    parameter int NCC_GAP      = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        sd_clk,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    input  logic        sd_cmd_in
);

    localparam int CNT_MAX = (RESP_TIMEOUT > FRAME_LEN) ? RESP_TIMEOUT : FRAME_LEN;
    localparam int CNT_W   = $clog2(((CNT_MAX > NCC_GAP) ? CNT_MAX : NCC_GAP) + 1);

    sd_state_e        state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       cmd_sync;
    logic             cmd_s;
    logic [DIV_W-1:0] clkdiv, div_cnt;
    logic             clk_en;
    logic [31:0]      arg_reg;
    logic [1:0]       resp_type;
    logic             done, timeout, crc_err;
    logic [31:0]      resp_arg;
    logic [5:0]       resp_idx;
    logic [6:0]       resp_crc;
    logic [47:0]      tx_shift;
    logic [46:0]      rx_shift;
    logic [6:0]       tx_crc, rx_crc;
    logic             busy, wr, start_acc, clk_run, div_hit, rise_stb, fall_stb;
    logic             tx_bit, tx_crc_en, rx_crc_en;
    logic             unused_bits;

    assign busy      = (state != S_IDLE);
    assign wr        = chipselect && !write_n;
    assign start_acc = wr && (address == ADDR_CTRL) && writedata[31] && !busy;
    assign clk_run   = clk_en || busy;
    assign div_hit   = clk_run && (div_cnt >= clkdiv);
    assign rise_stb  = div_hit && !sd_clk;
    assign fall_stb  = div_hit && sd_clk;
    assign cmd_s     = cmd_sync[1];
    assign unused_bits = ^{writedata, rx_shift[46:45]};

    // Idle CMD line is pulled high, so the synchroniser resets to 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cmd_sync <= 2'b11;
        else          cmd_sync <= {cmd_sync[0], sd_cmd_in};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            sd_clk  <= 1'b0;
        end else if (!clk_run) begin
            div_cnt <= '0;
            sd_clk  <= 1'b0;
        end else if (div_hit) begin
            div_cnt <= '0;
            sd_clk  <= ~sd_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:      if (start_acc) next_state = S_SEND;
            S_SEND:      if (fall_stb && cnt == CNT_W'(FRAME_LEN))
                             next_state = expects_resp(resp_type) ? S_WAIT_RESP : S_GAP;
            S_WAIT_RESP: if (rise_stb) begin
                             if (!cmd_s)                                 next_state = S_RECV;
                             else if (cnt == CNT_W'(RESP_TIMEOUT - 1))   next_state = S_GAP;
                         end
            S_RECV:      if (rise_stb && cnt == CNT_W'(FRAME_LEN - 1)) next_state = S_GAP;
            S_GAP:       if (rise_stb && cnt == CNT_W'(NCC_GAP - 1))   next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // The CRC is spliced in as the frame passes bit 40.
    assign tx_bit    = (cnt == CNT_W'(CRC_BITS)) ? tx_crc[6] : tx_shift[47];
    assign tx_crc_en = (state == S_SEND) && fall_stb && (cnt < CNT_W'(CRC_BITS));
    assign rx_crc_en = rise_stb && (((state == S_WAIT_RESP) && !cmd_s) ||
                                    ((state == S_RECV) && (cnt < CNT_W'(CRC_BITS))));

    sd_crc7 u_tx_crc (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (start_acc),
        .enable   (tx_crc_en),
        .data_bit (tx_shift[47]),
        .crc      (tx_crc)
    );

    sd_crc7 u_rx_crc (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (start_acc),
        .enable   (rx_crc_en),
        .data_bit (cmd_s),
        .crc      (rx_crc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state != next_state) begin
            cnt <= (next_state == S_RECV) ? CNT_W'(1) : '0;
        end else if (((state == S_SEND) && fall_stb) ||
                     ((state inside {S_WAIT_RESP, S_RECV, S_GAP}) && rise_stb)) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arg_reg    <= '0;
            resp_type  <= RESP_NONE;
            clkdiv     <= '1;
            clk_en     <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            crc_err    <= 1'b0;
            resp_arg   <= '0;
            resp_idx   <= '0;
            resp_crc   <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            sd_cmd_out <= 1'b1;
            sd_cmd_oe  <= 1'b0;
        end else begin
            if (wr && !busy && address == ADDR_ARG) arg_reg <= writedata;
            if (wr && !busy && address == ADDR_CLKDIV) begin
                clkdiv <= writedata[DIV_W-1:0];
                clk_en <= writedata[16];
            end
            if (start_acc) begin
                resp_type <= writedata[9:8];
                done      <= 1'b0;
                timeout   <= 1'b0;
                crc_err   <= 1'b0;
                tx_shift  <= {1'b0, 1'b1, writedata[5:0], arg_reg, 7'h00, 1'b1};
            end

            unique case (state)
                S_SEND: if (fall_stb) begin
                    if (cnt < CNT_W'(FRAME_LEN)) begin
                        sd_cmd_out <= tx_bit;
                        sd_cmd_oe  <= 1'b1;
                        tx_shift   <= (cnt == CNT_W'(CRC_BITS)) ? {tx_crc[5:0], 1'b1, 41'b0}
                                                                : {tx_shift[46:0], 1'b0};
                    end else begin
                        sd_cmd_out <= 1'b1;
                        sd_cmd_oe  <= 1'b0;
                    end
                end
                S_WAIT_RESP: if (rise_stb) begin
                    if (!cmd_s)                               rx_shift <= '0;
                    else if (cnt == CNT_W'(RESP_TIMEOUT - 1)) timeout  <= 1'b1;
                end
                S_RECV: if (rise_stb) begin
                    if (cnt < CNT_W'(FRAME_LEN - 1)) begin
                        rx_shift <= {rx_shift[45:0], cmd_s};
                    end else begin
                        resp_arg <= rx_shift[38:7];
                        resp_idx <= rx_shift[44:39];
                        resp_crc <= rx_shift[6:0];
                        crc_err  <= ((resp_type == RESP_CRC) && (rx_crc != rx_shift[6:0])) || !cmd_s;
                    end
                end
                S_GAP: if (rise_stb && cnt == CNT_W'(NCC_GAP - 1)) done <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_ARG:      readdata = arg_reg;
            ADDR_STATUS:   readdata = {27'b0, clk_en, crc_err, timeout, done, busy};
            ADDR_RESP_ARG: readdata = resp_arg;
            ADDR_RESP_HDR: readdata = {17'b0, resp_crc, 2'b0, resp_idx};
            ADDR_CLKDIV: begin
                readdata[DIV_W-1:0] = clkdiv;
                readdata[16]        = clk_en;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Self-checking bench for sd_cmd_engine: command table plus a card model that
// scoreboards transmitted frames and plays back responses.
module tb_sd_cmd_engine;
    import sd_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata, readdata;
    logic        sd_clk, sd_cmd_out, sd_cmd_oe, sd_cmd_in;

    sd_cmd_engine dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .sd_clk     (sd_clk),
        .sd_cmd_out (sd_cmd_out),
        .sd_cmd_oe  (sd_cmd_oe),
        .sd_cmd_in  (sd_cmd_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] arg;
        logic [31:0] ctrl;
        bit          reply;
        logic [47:0] reply_val;
        logic [47:0] exp_frame;
        logic [31:0] exp_status;
        logic [31:0] exp_resp_arg;
        logic [31:0] exp_resp_hdr;
        int          exp_gap;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [47:0] exp_q[$];
    bit          card_reply = 0;
    logic [47:0] card_val = '0;
    int          cap_cnt = 0;
    int          frames_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] build_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] hdr;
        logic [6:0]  c;
        logic        fb;
        hdr = {2'b01, idx, arg};
        c   = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = hdr[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return {hdr, c, 1'b1};
    endfunction

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1 d = readdata;
        chipselect = 1'b0;
    endtask

    // Waits for BUSY to drop; counts sd_clk rises after the CMD driver releases.
    task automatic wait_idle(input int max_cycles, output int gap_rises);
        logic prev_clk, was_oe;
        bit   released;
        gap_rises = 0; released = 0;
        prev_clk = sd_clk; was_oe = sd_cmd_oe;
        address = ADDR_STATUS;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (was_oe && !sd_cmd_oe) released = 1;
            was_oe = sd_cmd_oe;
            if (released && !prev_clk && sd_clk) gap_rises++;
            prev_clk = sd_clk;
            if (!readdata[0]) break;
        end
        check("busy_clear", {63'b0, readdata[0]}, 64'd0);
    endtask

    // Card model: captures frames on sd_clk rise, answers on sd_clk fall.
    initial begin : card_model
        logic [47:0] frame;
        bit          aborted;
        forever begin
            @(posedge sd_clk);
            if (sd_cmd_oe) begin
                frame = {47'b0, sd_cmd_out}; cap_cnt = 1; aborted = 0;
                while (cap_cnt < 48 && !aborted) begin
                    @(posedge sd_clk);
                    if (!sd_cmd_oe) aborted = 1;
                    else begin
                        frame = {frame[46:0], sd_cmd_out};
                        cap_cnt++;
                    end
                end
                if (!aborted) begin
                    frames_seen++;
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL tx_frame_unexpected: got %h expected none", frame);
                    end else begin
                        check("tx_frame", frame, exp_q.pop_front());
                    end
                    if (card_reply) begin
                        repeat (2) @(negedge sd_clk);
                        for (int i = 47; i >= 0; i--) begin
                            sd_cmd_in = card_val[i];
                            @(negedge sd_clk);
                        end
                        sd_cmd_in = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t        vecs[7];
        logic [31:0] rd;
        int          gap, rises, frames0, highs, r1, r2;
        logic        prev_clk, was_oe;
        bit          released, seen_to;

        vecs[0] = '{arg: 32'h0, ctrl: 32'h8000_0000, reply: 0, reply_val: 48'h0,
                    exp_frame: 48'h4000_0000_0095, exp_status: 32'h2,
                    exp_resp_arg: 32'h0, exp_resp_hdr: 32'h0, exp_gap: 8};
        vecs[1] = '{arg: 32'h1AA, ctrl: 32'h8000_0108, reply: 1, reply_val: 48'h0800_0001_AA13,
                    exp_frame: 48'h4800_0001_AA87, exp_status: 32'h2,
                    exp_resp_arg: 32'h1AA, exp_resp_hdr: 32'h0908, exp_gap: -1};
        vecs[2] = '{arg: 32'h1AA, ctrl: 32'h8000_0108, reply: 1, reply_val: 48'h0800_0011_AA13,
                    exp_frame: 48'h4800_0001_AA87, exp_status: 32'hA,
                    exp_resp_arg: 32'h11AA, exp_resp_hdr: 32'h0908, exp_gap: -1};
        vecs[3] = '{arg: 32'h1AA, ctrl: 32'h8000_0208, reply: 1, reply_val: 48'h0800_0011_AA13,
                    exp_frame: 48'h4800_0001_AA87, exp_status: 32'h2,
                    exp_resp_arg: 32'h11AA, exp_resp_hdr: 32'h0908, exp_gap: -1};
        vecs[4] = '{arg: 32'h1AA, ctrl: 32'h8000_0108, reply: 1, reply_val: 48'h0800_0001_AA12,
                    exp_frame: 48'h4800_0001_AA87, exp_status: 32'hA,
                    exp_resp_arg: 32'h1AA, exp_resp_hdr: 32'h0908, exp_gap: -1};
        vecs[5] = '{arg: 32'h1234_5678, ctrl: 32'h8000_0311, reply: 0, reply_val: 48'h0,
                    exp_frame: build_frame(6'd17, 32'h1234_5678), exp_status: 32'h2,
                    exp_resp_arg: 32'h1AA, exp_resp_hdr: 32'h0908, exp_gap: 8};
        vecs[6] = '{arg: 32'h40FF_8000, ctrl: 32'h8000_0229, reply: 1, reply_val: 48'h3F80_FF80_00FF,
                    exp_frame: build_frame(6'd41, 32'h40FF_8000), exp_status: 32'h2,
                    exp_resp_arg: 32'h80FF_8000, exp_resp_hdr: 32'h7F3F, exp_gap: -1};

        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; sd_cmd_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sd_clk", {63'b0, sd_clk}, 64'd0);
        check("rst_oe", {63'b0, sd_cmd_oe}, 64'd0);
        check("rst_cmd_out", {63'b0, sd_cmd_out}, 64'd1);
        reset_n = 1'b1;
        bus_read(ADDR_STATUS, rd);   check("rst_status", rd, 32'h0);
        bus_read(ADDR_CLKDIV, rd);   check("rst_clkdiv", rd, 32'hFF);
        bus_read(ADDR_ARG, rd);      check("rst_arg", rd, 32'h0);
        bus_read(ADDR_RESP_ARG, rd); check("rst_resp_arg", rd, 32'h0);
        bus_read(ADDR_RESP_HDR, rd); check("rst_resp_hdr", rd, 32'h0);
        bus_read(3'd6, rd);          check("unmapped6", rd, 32'h0);
        bus_read(3'd7, rd);          check("unmapped7", rd, 32'h0);

        bus_write(ADDR_CLKDIV, 32'h0);
        foreach (vecs[k]) begin
            card_reply = vecs[k].reply;
            card_val   = vecs[k].reply_val;
            bus_write(ADDR_ARG, vecs[k].arg);
            bus_read(ADDR_ARG, rd);
            check($sformatf("v%0d_arg", k), rd, vecs[k].arg);
            exp_q.push_back(vecs[k].exp_frame);
            bus_write(ADDR_CTRL, vecs[k].ctrl);
            wait_idle(4000, gap);
            if (vecs[k].exp_gap >= 0) check($sformatf("v%0d_gap_rises", k), gap, vecs[k].exp_gap);
            bus_read(ADDR_STATUS, rd);   check($sformatf("v%0d_status", k), rd, vecs[k].exp_status);
            bus_read(ADDR_RESP_ARG, rd); check($sformatf("v%0d_resp_arg", k), rd, vecs[k].exp_resp_arg);
            bus_read(ADDR_RESP_HDR, rd); check($sformatf("v%0d_resp_hdr", k), rd, vecs[k].exp_resp_hdr);
            check($sformatf("v%0d_frame_seen", k), exp_q.size(), 0);
        end

        // No card answer: TIMEOUT on exactly the 64th rise after release.
        card_reply = 0;
        bus_write(ADDR_ARG, 32'h1AA);
        exp_q.push_back(48'h4800_0001_AA87);
        bus_write(ADDR_CTRL, 32'h8000_0108);
        address = ADDR_STATUS;
        rises = 0; released = 0; seen_to = 0;
        prev_clk = sd_clk; was_oe = sd_cmd_oe;
        for (int i = 0; i < 2000 && !seen_to; i++) begin
            @(negedge clk);
            if (was_oe && !sd_cmd_oe) released = 1;
            was_oe = sd_cmd_oe;
            if (released && !prev_clk && sd_clk) rises++;
            prev_clk = sd_clk;
            if (readdata[2]) seen_to = 1;
        end
        check("timeout_rises", rises, 64);
        wait_idle(2000, gap);
        bus_read(ADDR_STATUS, rd);   check("to_status", rd, 32'h6);
        bus_read(ADDR_RESP_ARG, rd); check("to_resp_arg_kept", rd, 32'h80FF_8000);
        bus_read(ADDR_RESP_HDR, rd); check("to_resp_hdr_kept", rd, 32'h7F3F);
        check("to_frame_seen", exp_q.size(), 0);

        // CLKDIV=3 with CLK_EN: period 8; writes while BUSY are dropped.
        bus_write(ADDR_CLKDIV, 32'h0001_0003);
        r1 = -1; r2 = -1; prev_clk = sd_clk;
        for (int i = 0; i < 200 && r2 < 0; i++) begin
            @(negedge clk);
            if (!prev_clk && sd_clk) begin
                if (r1 < 0) r1 = i;
                else        r2 = i;
            end
            prev_clk = sd_clk;
        end
        check("div3_period", r2 - r1, 8);
        bus_write(ADDR_ARG, 32'h0);
        exp_q.push_back(48'h4000_0000_0095);
        frames0 = frames_seen;
        bus_write(ADDR_CTRL, 32'h8000_0000);
        bus_write(ADDR_CTRL, 32'h8000_0000);
        bus_write(ADDR_CLKDIV, 32'h0001_0000);
        wait_idle(3000, gap);
        check("div3_gap_rises", gap, 8);
        repeat (20) @(negedge clk);
        check("busy_write_frames", frames_seen - frames0, 1);
        bus_read(ADDR_CLKDIV, rd); check("busy_clkdiv_kept", rd, 32'h0001_0003);
        bus_read(ADDR_STATUS, rd); check("div3_status", rd, 32'h12);

        bus_write(ADDR_CLKDIV, 32'h0000_0003);
        repeat (2) @(negedge clk);
        highs = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (sd_clk) highs++;
        end
        check("clk_off_idle", highs, 0);

        // Reset in the middle of SEND, then a clean CMD0.
        bus_write(ADDR_CLKDIV, 32'h0);
        bus_write(ADDR_ARG, 32'h0);
        cap_cnt = 0;
        bus_write(ADDR_CTRL, 32'h8000_0000);
        for (int i = 0; i < 500 && cap_cnt != 20; i++) @(negedge clk);
        check("reset_point_reached", cap_cnt, 20);
        reset_n = 1'b0;
        #1;
        check("midrst_oe", {63'b0, sd_cmd_oe}, 64'd0);
        check("midrst_sd_clk", {63'b0, sd_clk}, 64'd0);
        check("midrst_cmd_out", {63'b0, sd_cmd_out}, 64'd1);
        bus_read(ADDR_STATUS, rd); check("midrst_status", rd, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_write(ADDR_CLKDIV, 32'h0);
        bus_write(ADDR_ARG, 32'h0);
        exp_q.push_back(48'h4000_0000_0095);
        bus_write(ADDR_CTRL, 32'h8000_0000);
        wait_idle(3000, gap);
        check("post_rst_gap_rises", gap, 8);
        bus_read(ADDR_STATUS, rd); check("post_rst_status", rd, 32'h2);
        check("post_rst_frame_seen", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
